// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Round-robin arbiter sharing the single register-file write port between the
// ALU write-back path (requester 0) and the load return path (requester 1).
// The winning write is registered and presented to the register file one
// cycle after the handshake. Saturating per-requester stall counters are
// kept for performance debug.
module rf_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int RR_INIT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              prio,
    output logic [CNT_W-1:0]  stall0_cnt,
    output logic [CNT_W-1:0]  stall1_cnt
);

    localparam logic             PRIO_INIT = (RR_INIT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              gnt0;
    logic              gnt1;

    logic              rf_we_d,     rf_we_q;
    logic [ADDR_W-1:0] rf_w_addr_d, rf_w_addr_q;
    logic [DATA_W-1:0] rf_w_data_d, rf_w_data_q;
    logic              prio_d,      prio_q;
    logic [CNT_W-1:0]  stall0_d,    stall0_q;
    logic [CNT_W-1:0]  stall1_d,    stall1_q;

    // Grant: an uncontested request always wins; on contention prio decides.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | ~prio_q);
        gnt1 = req1_valid & (~req0_valid |  prio_q);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Next write-port contents; writes to register 0 handshake but never enable.
    always_comb begin
        rf_we_d     = 1'b0;
        rf_w_addr_d = rf_w_addr_q;
        rf_w_data_d = rf_w_data_q;
        if (gnt0) begin
            rf_we_d     = |req0_addr;
            rf_w_addr_d = req0_addr;
            rf_w_data_d = req0_data;
        end else if (gnt1) begin
            rf_we_d     = |req1_addr;
            rf_w_addr_d = req1_addr;
            rf_w_data_d = req1_data;
        end
    end

    // Priority moves to the other requester after every grant, contested or not.
    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end

    // Stall counters count valid-but-not-ready cycles and stick at all-ones.
    always_comb begin
        stall0_d = stall0_q;
        stall1_d = stall1_q;
        if (req0_valid && !gnt0 && (stall0_q != CNT_MAX)) begin
            stall0_d = stall0_q + CNT_ONE;
        end
        if (req1_valid && !gnt1 && (stall1_q != CNT_MAX)) begin
            stall1_d = stall1_q + CNT_ONE;
        end
    end

    // State registers; reset discards any write captured in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q     <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            prio_q      <= PRIO_INIT;
            stall0_q    <= '0;
            stall1_q    <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_w_addr_q <= rf_w_addr_d;
            rf_w_data_q <= rf_w_data_d;
            prio_q      <= prio_d;
            stall0_q    <= stall0_d;
            stall1_q    <= stall1_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_w_addr  = rf_w_addr_q;
    assign rf_w_data  = rf_w_data_q;
    assign prio       = prio_q;
    assign stall0_cnt = stall0_q;
    assign stall1_cnt = stall1_q;

endmodule
